// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: op encoding and FSM states.
// The optional rotate-right mode is enabled by defining ITER_SHIFTER_ROR_EN.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit-position shift step.
// With ITER_SHIFTER_ROR_EN defined, SH_NONE becomes a one-bit rotate right.
module shift_step
    import shift_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] d,
    input  logic [1:0]   op,
    output logic [W-1:0] d_next
);

    always_comb begin
        d_next = d;
        case (shift_op_t'(op))
            SH_LSL:  d_next = {d[W-2:0], 1'b0};
            SH_LSR:  d_next = {1'b0, d[W-1:1]};
            SH_ASR:  d_next = {d[W-1], d[W-1:1]};
`ifdef ITER_SHIFTER_ROR_EN
            SH_NONE: d_next = {d[0], d[W-1:1]};
`else
            SH_NONE: d_next = d;
`endif
            default: d_next = d;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one bit position per clock, valid/ready at both ends.
// Define ITER_SHIFTER_ROR_EN to turn op 00 with a nonzero amount into rotate right.
module iter_shifter
    import shift_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic [1:0]             in_op,
    input  logic [$clog2(W)-1:0]   in_amt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   busy
);

    localparam int AW = $clog2(W);

    state_t         state_q;
    shift_op_t      op_q;
    logic [W-1:0]   work_q;
    logic [W-1:0]   work_d;
    logic [AW-1:0]  cnt_q;
    logic [W-1:0]   out_data_q;
    logic           out_valid_q;
    logic           skip_d;

    shift_step #(.W(W)) u_step (
        .d      (work_q),
        .op     (op_q),
        .d_next (work_d)
    );

    // Requests that need no shifting go straight to DONE with the operand as result.
`ifdef ITER_SHIFTER_ROR_EN
    assign skip_d = (in_amt == '0);
`else
    assign skip_d = (in_amt == '0) || (shift_op_t'(in_op) == SH_NONE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= SH_NONE;
            work_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= shift_op_t'(in_op);
                        work_q <= in_data;
                        cnt_q  <= in_amt;
                        if (skip_d) begin
                            out_data_q  <= in_data;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == AW'(1)) begin
                        out_data_q  <= work_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Ready depends only on state, so a DONE->IDLE handoff never overlaps an accept.
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: closed-form result/latency model plus directed vectors.
// Expectations for op 00 follow ITER_SHIFTER_ROR_EN.
module tb_iter_shifter;

    localparam int W  = 16;
    localparam int AW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_op = 2'b00;
    logic [AW-1:0] in_amt = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    iter_shifter #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Result computed in one go with shift operators, not step by step.
    function automatic logic [W-1:0] model_res(input logic [W-1:0] d, input logic [1:0] op,
                                               input int amt);
        logic signed [W-1:0] s;
        logic [W-1:0] r;
        s = d;
        case (op)
            2'b01: r = d << amt;
            2'b10: r = d >> amt;
            2'b11: r = s >>> amt;
            default: begin
`ifdef ITER_SHIFTER_ROR_EN
                r = (amt == 0) ? d : ((d >> amt) | (d << (W - amt)));
`else
                r = d;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [1:0] op, input int amt);
`ifdef ITER_SHIFTER_ROR_EN
        return (amt == 0) ? 1 : amt + 1;
`else
        return (amt == 0 || op == 2'b00) ? 1 : amt + 1;
`endif
    endfunction

    // Cycle-level model: idle / counting down to result / presenting result.
    logic         m_busy, m_valid;
    logic [W-1:0] m_data, m_res;
    int           m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_res   <= '0;
            m_cnt   <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                if (model_lat(in_op, int'(in_amt)) == 1) begin
                    m_valid <= 1'b1;
                    m_data  <= model_res(in_data, in_op, int'(in_amt));
                end else begin
                    m_cnt <= model_lat(in_op, int'(in_amt)) - 1;
                    m_res <= model_res(in_data, in_op, int'(in_amt));
                end
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid <= 1'b0;
                m_busy  <= 1'b0;
            end
        end else begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_data  <= m_res;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_in_ready",  {31'b0, in_ready},  {31'b0, !m_busy});
            chk("cyc_busy",      {31'b0, busy},      {31'b0, m_busy});
            chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            chk("cyc_out_data",  {16'b0, out_data},  {16'b0, m_data});
        end
    end

    task automatic issue(input logic [W-1:0] d, input logic [1:0] op, input int amt);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) chk("wait_in_ready", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_op    = op;
        in_amt   = AW'(amt);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Issue, measure latency to out_valid, compare with literal expectations, then drain.
    task automatic run_op(input string name, input logic [W-1:0] d, input logic [1:0] op,
                          input int amt, input logic [W-1:0] exp_data, input int exp_lat);
        int lat;
        issue(d, op, amt);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, "_lat"},  lat, exp_lat);
        chk({name, "_data"}, {16'b0, out_data}, {16'b0, exp_data});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [W-1:0] held;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_busy",     {31'b0, busy}, 0);
        chk("rst_out_data", {16'b0, out_data}, 0);

        run_op("lsl4",   16'h0001, 2'b01, 4,  16'h0010, 5);
        run_op("asr15",  16'h8000, 2'b11, 15, 16'hFFFF, 16);
        run_op("lsr15",  16'h8000, 2'b10, 15, 16'h0001, 16);
        run_op("amt0",   16'hBEEF, 2'b10, 0,  16'hBEEF, 1);
        run_op("lsl15",  16'hFFFF, 2'b01, 15, 16'h8000, 16);
        run_op("asr4p",  16'h7FF0, 2'b11, 4,  16'h07FF, 5);
        run_op("lsr1",   16'hA5A5, 2'b10, 1,  16'h52D2, 2);
`ifdef ITER_SHIFTER_ROR_EN
        run_op("op00",   16'h000F, 2'b00, 4,  16'hF000, 5);
`else
        run_op("op00",   16'h000F, 2'b00, 4,  16'h000F, 1);
`endif

        // Backpressure in DONE, with a new request waiting across the handoff.
        issue(16'h1234, 2'b01, 1);
        @(posedge clk); #1;
        chk("bp_valid", {31'b0, out_valid}, 1);
        held = out_data;
        chk("bp_data", {16'b0, held}, 32'h2468);
        in_valid = 1'b1; in_data = 16'h00F0; in_op = 2'b10; in_amt = AW'(4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'b0, out_valid}, 1);
            chk("bp_hold_data",  {16'b0, out_data}, {16'b0, held});
            chk("bp_in_ready",   {31'b0, in_ready}, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hand_valid", {31'b0, out_valid}, 0);
        chk("hand_ready", {31'b0, in_ready}, 1);
        chk("hand_busy",  {31'b0, busy}, 0);
        chk("hand_data",  {16'b0, out_data}, {16'b0, held});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next_accept", {31'b0, busy}, 1);
        chk("next_hold_data", {16'b0, out_data}, {16'b0, held});
        begin
            int t;
            t = 0;
            while (!out_valid && t < 100) begin
                @(posedge clk); #1; t++;
            end
            chk("next_lat", t, 4);
            chk("next_data", {16'b0, out_data}, 32'h000F);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a shift.
        issue(16'h0003, 2'b01, 10);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  {31'b0, in_ready}, 1);
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_busy",      {31'b0, busy}, 0);
        chk("mid_rst_out_data",  {16'b0, out_data}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("post_rst", 16'h0101, 2'b11, 8, 16'h0001, 9);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

endmodule
